// File: rtl/rtib_core_if.sv
// rtib_core_if: host-side bus of the real-time input buffer.
// The capture core sits on the slave modport; host logic drives the master side.
interface rtib_core_if #(
    parameter int DEPTH = 1024
);
    logic                     flush;
    logic                     auto_start;
    logic [7:0]               ttl_in;
    logic [7:0]               rise_mask;
    logic [7:0]               fall_mask;
    logic [63:0]              counter;
    logic                     rd_en;
    logic [127:0]             dout;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     event_captured;
    logic                     overflow_error;
    logic [127:0]             overflow_error_data;
    logic                     underflow_error;

    modport master (
        output flush, auto_start, ttl_in, rise_mask, fall_mask, counter, rd_en,
        input  dout, empty, full, count, event_captured, overflow_error,
               overflow_error_data, underflow_error
    );

    modport slave (
        input  flush, auto_start, ttl_in, rise_mask, fall_mask, counter, rd_en,
        output dout, empty, full, count, event_captured, overflow_error,
               overflow_error_data, underflow_error
    );
endinterface

// File: rtl/rtib_core.sv
// rtib_core: timestamps masked TTL edges into a FWFT FIFO with overflow/underflow reporting.
module rtib_core #(
    parameter int DEPTH     = 1024,
    parameter int THRESHOLD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    rtib_core_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [127:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_ttl_prev;
    logic          r_event_captured;
    logic          r_overflow_error;
    logic [127:0]  r_overflow_error_data;
    logic          r_underflow_error;

    logic [7:0]    w_rise;
    logic [7:0]    w_fall;
    logic          w_event;
    logic          w_empty;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;
    logic [127:0]  w_entry;

    assign w_rise  = bus.ttl_in & ~r_ttl_prev & bus.rise_mask;
    assign w_fall  = ~bus.ttl_in & r_ttl_prev & bus.fall_mask;
    assign w_event = bus.auto_start && |(w_rise | w_fall) && !bus.flush;
    assign w_empty = (r_count == '0);
    // full comes from the registered count, so a same-cycle pop cannot make room
    assign w_full  = (r_count >= CW'(THRESHOLD));
    assign w_wr    = w_event && !w_full;
    assign w_rd    = bus.rd_en && !w_empty && !bus.flush;
    assign w_entry = {bus.counter, 40'h0, w_fall, w_rise, bus.ttl_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr              <= '0;
            r_rd_ptr              <= '0;
            r_count               <= '0;
            r_ttl_prev            <= '0;
            r_event_captured      <= 1'b0;
            r_overflow_error      <= 1'b0;
            r_overflow_error_data <= '0;
            r_underflow_error     <= 1'b0;
        end else begin
            r_ttl_prev        <= bus.ttl_in;
            r_event_captured  <= w_wr;
            r_overflow_error  <= w_event && w_full;
            r_underflow_error <= bus.rd_en && w_empty && !bus.flush;
            if (w_event && w_full)
                r_overflow_error_data <= w_entry;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
                r_rd_ptr <= w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
                r_count  <= r_count + CW'(w_wr) - CW'(w_rd);
            end
        end
    end

    // storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (!reset && w_wr)
            r_mem[r_wr_ptr] <= w_entry;
    end

    assign bus.dout                = w_empty ? 128'h0 : r_mem[r_rd_ptr];
    assign bus.empty               = w_empty;
    assign bus.full                = w_full;
    assign bus.count               = r_count;
    assign bus.event_captured      = r_event_captured;
    assign bus.overflow_error      = r_overflow_error;
    assign bus.overflow_error_data = r_overflow_error_data;
    assign bus.underflow_error     = r_underflow_error;
endmodule

// File: tb/tb_rtib_core.sv
// tb_rtib_core: directed checks of rtib_core with DEPTH=8, THRESHOLD=4.
module tb_rtib_core;
    logic clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_fail = 0;
    logic [127:0] q [$];
    logic [63:0] ts;
    logic [7:0] nt;

    always #5 clk = ~clk;

    rtib_core_if #(.DEPTH(8)) bus ();
    rtib_core #(.DEPTH(8), .THRESHOLD(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [127:0] ent(logic [63:0] t, logic [7:0] ttl, logic [7:0] rise, logic [7:0] fall);
        return {t, 40'h0, fall, rise, ttl};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the edge; outputs are sampled at the falling edge
    task automatic tick;
        @(posedge clk);
        #1;
        bus.counter = bus.counter + 64'd1;
    endtask

    initial begin
        reset = 1'b1;
        bus.flush = 0; bus.auto_start = 0; bus.ttl_in = 0; bus.rise_mask = 0;
        bus.fall_mask = 0; bus.counter = 0; bus.rd_en = 0;
        tick; tick;
        reset = 1'b0;
        #4;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_evcap", bus.event_captured, 0);
        chk("rst_ovf", bus.overflow_error, 0);
        chk("rst_unf", bus.underflow_error, 0);
        chk("rst_ovf_data", bus.overflow_error_data, 0);

        // single rising edge
        tick; bus.auto_start = 1; bus.rise_mask = 8'hFF; bus.counter = 64'd100; bus.ttl_in = 8'h05;
        tick; #4;
        chk("single_evcap", bus.event_captured, 1);
        chk("single_count", bus.count, 1);
        chk("single_empty", bus.empty, 0);
        chk("single_dout", bus.dout, ent(64'd100, 8'h05, 8'h05, 8'h00));
        tick; #4;
        chk("single_evcap_off", bus.event_captured, 0);
        tick; bus.rd_en = 1;
        tick; bus.rd_en = 0; #4;
        chk("single_drain_empty", bus.empty, 1);
        chk("single_drain_dout", bus.dout, 0);
        chk("single_drain_unf", bus.underflow_error, 0);

        // mask filtering
        tick; bus.rise_mask = 8'h00; bus.fall_mask = 8'h01; bus.ttl_in = 8'h01;
        tick; bus.counter = 64'd200; bus.ttl_in = 8'h00; #4;
        chk("mask_masked_rise", bus.count, 0);
        tick; #4;
        chk("mask_fall_count", bus.count, 1);
        chk("mask_fall_evcap", bus.event_captured, 1);
        tick; bus.counter = 64'd210; bus.ttl_in = 8'h02;
        tick; #4;
        chk("mask_count", bus.count, 1);
        chk("mask_evcap_off", bus.event_captured, 0);
        chk("mask_dout", bus.dout, ent(64'd200, 8'h00, 8'h00, 8'h01));
        tick; bus.rd_en = 1;
        tick; bus.rd_en = 0; #4;
        chk("mask_drain_empty", bus.empty, 1);

        // fill to threshold, fifth edge dropped
        tick; bus.rise_mask = 8'h01; bus.counter = 64'd300; bus.ttl_in = 8'h03;
        tick; bus.ttl_in = 8'h02;
        tick; bus.ttl_in = 8'h03;
        tick; bus.ttl_in = 8'h02;
        tick; bus.ttl_in = 8'h03; #4;
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 4);
        tick; #4;
        chk("ovf_pulse", bus.overflow_error, 1);
        chk("ovf_data", bus.overflow_error_data, ent(64'd304, 8'h03, 8'h01, 8'h00));
        chk("ovf_count", bus.count, 4);
        chk("ovf_no_evcap", bus.event_captured, 0);
        chk("ovf_head", bus.dout, ent(64'd300, 8'h03, 8'h01, 8'h00));
        tick; #4;
        chk("ovf_pulse_end", bus.overflow_error, 0);
        chk("ovf_data_hold", bus.overflow_error_data, ent(64'd304, 8'h03, 8'h01, 8'h00));
        tick; bus.rd_en = 1; #4;
        chk("pop_keeps_full", bus.full, 1);
        tick; #4;
        chk("full_lifted", bus.full, 0);
        chk("pop_count3", bus.count, 3);
        tick; bus.rd_en = 0; #4;
        chk("pop_count2", bus.count, 2);
        chk("pop_head", bus.dout, ent(64'd302, 8'h03, 8'h01, 8'h00));

        // simultaneous read and write at count=2
        tick; bus.rd_en = 1; bus.ttl_in = 8'h02; ts = bus.counter;
        tick; bus.rd_en = 0; #4;
        chk("rw_count", bus.count, 2);
        chk("rw_head", bus.dout, ent(64'd303, 8'h02, 8'h00, 8'h01));
        chk("rw_evcap", bus.event_captured, 1);
        tick; bus.rd_en = 1;
        tick; #4;
        chk("rw_tail", bus.dout, ent(ts, 8'h02, 8'h00, 8'h01));
        chk("rw_tail_count", bus.count, 1);
        tick; bus.rd_en = 0; #4;
        chk("rw_drain_empty", bus.empty, 1);

        // wrap-around with interleaved reads
        for (int i = 0; i < 20; i++) begin
            tick;
            bus.rd_en = 0;
            nt = bus.ttl_in ^ 8'h01;
            q.push_back(ent(bus.counter, nt, nt & ~bus.ttl_in & 8'h01, ~nt & bus.ttl_in & 8'h01));
            bus.ttl_in = nt;
            tick;
            #4;
            chk("wrap_count", bus.count, q.size());
            if (q.size() >= 2) begin
                chk("wrap_dout", bus.dout, q[0]);
                void'(q.pop_front());
                bus.rd_en = 1;
            end
        end
        while (q.size() > 0) begin
            tick; bus.rd_en = 1; #4;
            chk("wrap_drain", bus.dout, q[0]);
            void'(q.pop_front());
        end
        tick; bus.rd_en = 0; #4;
        chk("wrap_empty", bus.empty, 1);
        chk("wrap_no_ovf", bus.overflow_error, 0);
        chk("wrap_no_unf", bus.underflow_error, 0);

        // flush with a coincident event
        for (int k = 0; k < 3; k++) begin
            tick; bus.ttl_in = bus.ttl_in ^ 8'h01;
        end
        tick; #4;
        chk("pre_flush_count", bus.count, 3);
        tick; bus.flush = 1; bus.ttl_in = bus.ttl_in ^ 8'h01;
        tick; bus.flush = 0; #4;
        chk("flush_count", bus.count, 0);
        chk("flush_empty", bus.empty, 1);
        chk("flush_no_ovf", bus.overflow_error, 0);
        chk("flush_no_evcap", bus.event_captured, 0);
        chk("flush_dout", bus.dout, 0);
        tick; #4;
        chk("flush_prev_tracked", bus.count, 0);

        // underflow
        tick; bus.rd_en = 1;
        tick; bus.rd_en = 0; #4;
        chk("unf_pulse", bus.underflow_error, 1);
        tick; #4;
        chk("unf_pulse_end", bus.underflow_error, 0);

        // reset mid-stream, then first-cycle edge from ttl_prev=0
        tick; bus.ttl_in = 8'h03;
        tick; bus.ttl_in = 8'h02;
        tick; reset = 1; bus.ttl_in = 8'h03;
        tick; reset = 0; ts = bus.counter; #4;
        chk("mrst_count", bus.count, 0);
        chk("mrst_empty", bus.empty, 1);
        chk("mrst_full", bus.full, 0);
        chk("mrst_dout", bus.dout, 0);
        chk("mrst_evcap", bus.event_captured, 0);
        chk("mrst_ovf_data", bus.overflow_error_data, 0);
        tick; #4;
        chk("post_rst_count", bus.count, 1);
        chk("post_rst_entry", bus.dout, ent(ts, 8'h03, 8'h01, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
